serial_transmitter: RTL
=======================

Name: serial_transmitter

Overview:
Upstream stage of the serial receiver. It accepts 7-bit words through a valid/ready handshake and buffers them in a small FIFO. Each word is serialised onto a single line as: start bit, 7 data bits MSB first, parity bit, stop bit(s). Line format and bit timing match the receiver, so `serial_out` connects directly to its `serial_in`.

Parameters:
- BIT_CYCLES, 1, clock cycles each bit is held on the line (1 = one bit per clock, the receiver's native rate); legal 1..255.
- STOP_BITS, 1, number of high stop bits after parity; legal 1..4.
- FIFO_DEPTH, 4, input word buffer entries; power of two, 2..16.
- PARITY_ODD, 0, 0 = parity bit is XOR of the 7 data bits (even); 1 = inverted.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is presented.
- in_ready  output  1  FIFO can accept; equals !full.
- in_data  input  7  word to transmit.
- serial_out  output  1  line; idle high; registered output.
- busy  output  1  high while FSM is not IDLE or FIFO is non-empty.
- frame_done  output  1  one-cycle pulse when a frame's last stop-bit cycle completes.
- fifo_count  output  clog2(FIFO_DEPTH)+1  words currently buffered.

Behaviour:
- Reset:
  - Sampled only on rising clk.
  - Next edge: serial_out=1, busy=0, frame_done=0, fifo_count=0, in_ready=1.
  - FSM to IDLE; bit/cycle counters and FIFO pointers cleared.
  - Mid-frame reset aborts the frame immediately, so the line returns high the following cycle and buffered words are discarded.
- Push:
  - Occurs when in_valid && in_ready at an edge.
  - in_ready is combinational !full, so no push happens when full, even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full leaves fifo_count unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: serial_out=1. If FIFO non-empty: pop the head into the shift register, compute the parity bit (^word ^ PARITY_ODD), go to START.
  - START: serial_out=0 for BIT_CYCLES cycles, then DATA.
  - DATA: serial_out = shift_reg[6] (MSB first), each held BIT_CYCLES cycles. Shift left after each bit. After 7 bits go to PARITY.
  - PARITY: serial_out = stored parity bit for BIT_CYCLES cycles, then STOP.
  - STOP: serial_out=1 for STOP_BITS*BIT_CYCLES cycles. At completion, pulse frame_done. If the FIFO is non-empty, pop and go directly to START (no extra idle cycle); otherwise go to IDLE.
- Latency:
  - A word pushed at edge k into an empty FIFO with the FSM in IDLE is popped at edge k+1.
  - serial_out=0 from edge k+1.
- Frame length: (9+STOP_BITS)*BIT_CYCLES cycles; back-to-back frames are gap-free.
- Cycle counter: counts 0..BIT_CYCLES-1 and wraps. The bit counter advances only on wrap. With BIT_CYCLES=1 a bit changes every clock.
- The data word is latched at pop, so FIFO contents and in_data changes never disturb a frame in flight.
- The FIFO is a circular buffer; pointers wrap modulo FIFO_DEPTH.
  - Full: count==FIFO_DEPTH.
  - Empty: count==0.

Test Plan:
- Single word, defaults: push 7'h55 at edge k → serial_out from edge k+1 = 0,1,0,1,0,1,0,1,0(parity),1(stop). frame_done pulses on the stop cycle; busy falls after it.
- Parity: 7'h07 → parity bit 1; 7'h00 → 0; with PARITY_ODD=1, 7'h07 → 0. Loop serial_out into the receiver and check data_out and parity_ok_n=0 for all 128 values.
- Back-to-back and full: push 6 words with FIFO_DEPTH=4 while transmitting → in_ready low once count hits 4, no word lost or duplicated, frames contiguous with exactly STOP_BITS high bits between them.
- Timing: BIT_CYCLES=3, STOP_BITS=2 → each bit held 3 cycles, stop high 6 cycles, total frame 33 cycles.
- Reset mid-DATA after 3 bits with 2 words queued → serial_out=1 next cycle, fifo_count=0, no frame_done, and the next push transmits a clean frame.
- Simultaneous push and pop at count=2 → count stays 2, and order is preserved across pointer wrap.

Source files
------------

// File: rtl/serial_transmitter.sv
// -----------------------------------------------------------------------------
// serial_transmitter
//
// Purpose:
//   Upstream stage of the serial receiver. Accepts 7-bit words over a
//   valid/ready handshake, buffers them in a small circular FIFO, and
//   serialises each word onto a single idle-high line as:
//     start (0), 7 data bits MSB first, parity, STOP_BITS stop bits (1).
//   Each bit is held for BIT_CYCLES clocks. Back-to-back frames are gap-free.
//
// Parameters:
//   BIT_CYCLES  clocks per bit on the line (1..255)
//   STOP_BITS   number of stop bits (1..4)
//   FIFO_DEPTH  input buffer entries (power of two, 2..16)
//   PARITY_ODD  0: parity = XOR of data bits, 1: inverted
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    in_data is presented
//   in_ready    FIFO can accept a word (combinational !full)
//   in_data     7-bit word to transmit
//   serial_out  registered serial line, idle high
//   busy        FSM not idle or FIFO non-empty
//   frame_done  one-cycle pulse during the last cycle of the last stop bit
//   fifo_count  number of words currently buffered
// -----------------------------------------------------------------------------
module serial_transmitter #(
    parameter int BIT_CYCLES = 1,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [6:0]                    in_data,
    output logic                          serial_out,
    output logic                          busy,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [7:0]       CYC_LAST  = 8'(BIT_CYCLES - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [2:0]       DATA_LAST = 3'd6;
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic             PAR_INV   = (PARITY_ODD != 0);

    // FSM encoding
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [6:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic [6:0] head;

    // ------------------------------------------------------------------
    // Serialiser state
    // ------------------------------------------------------------------
    logic [2:0] state,     state_nx;
    logic [7:0] cyc_cnt,   cyc_nx;
    logic [2:0] bit_cnt,   bit_nx;
    logic [6:0] shift_reg, shift_nx;
    logic       parity_q,  parity_nx;
    logic       line_q,    line_nx;

    logic bit_end;
    logic stop_done;

    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    assign in_ready = !full;
    // A pop in the same cycle does not open a slot: in_ready depends on
    // count only, so a full FIFO never accepts.
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr];

    // Cycle counter wraps at BIT_CYCLES-1; everything else moves on wrap.
    assign bit_end   = (cyc_cnt == CYC_LAST);
    assign stop_done = (state == S_STOP) && bit_end && (bit_cnt == STOP_LAST);

    // Pop either from idle, or at the very end of a frame so that the next
    // start bit follows the last stop bit without an idle cycle.
    assign pop = !empty && ((state == S_IDLE) || stop_done);

    assign serial_out = line_q;
    assign frame_done = stop_done;
    assign busy       = (state != S_IDLE) || !empty;
    assign fifo_count = count;

    // ------------------------------------------------------------------
    // FIFO memory write
    // ------------------------------------------------------------------
    // NOTE: the storage array has no reset; only the pointers and count
    // define which entries are valid, and leaving the array unreset lets it
    // map onto plain registers or distributed RAM without a clear path.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers and count
    // ------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. The line value is computed for the state being
    // entered, so serial_out is registered yet aligned with the state.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        state_nx  = state;
        cyc_nx    = bit_end ? 8'd0 : cyc_cnt + 8'd1;
        bit_nx    = bit_cnt;
        shift_nx  = shift_reg;
        parity_nx = parity_q;
        line_nx   = line_q;

        case (state)
            S_IDLE: begin
                cyc_nx  = 8'd0;
                bit_nx  = 3'd0;
                line_nx = 1'b1;
                if (pop) begin
                    shift_nx  = head;
                    parity_nx = (^head) ^ PAR_INV;
                    state_nx  = S_START;
                    line_nx   = 1'b0;
                end
            end

            S_START: begin
                if (bit_end) begin
                    state_nx = S_DATA;
                    bit_nx   = 3'd0;
                    line_nx  = shift_reg[6];
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt == DATA_LAST) begin
                        state_nx = S_PARITY;
                        line_nx  = parity_q;
                    end else begin
                        // Next bit out is the one just below the current MSB.
                        shift_nx = {shift_reg[5:0], 1'b0};
                        line_nx  = shift_reg[5];
                        bit_nx   = bit_cnt + 3'd1;
                    end
                end
            end

            S_PARITY: begin
                if (bit_end) begin
                    state_nx = S_STOP;
                    bit_nx   = 3'd0;
                    line_nx  = 1'b1;
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        bit_nx = 3'd0;
                        if (pop) begin
                            shift_nx  = head;
                            parity_nx = (^head) ^ PAR_INV;
                            state_nx  = S_START;
                            line_nx   = 1'b0;
                        end else begin
                            state_nx = S_IDLE;
                            line_nx  = 1'b1;
                        end
                    end else begin
                        bit_nx = bit_cnt + 3'd1;
                    end
                end
            end

            default: begin
                state_nx = S_IDLE;
                cyc_nx   = 8'd0;
                bit_nx   = 3'd0;
                line_nx  = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Serialiser registers. Reset aborts any frame in flight; the line is
    // back high on the edge that samples rst.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cyc_cnt   <= 8'd0;
            bit_cnt   <= 3'd0;
            shift_reg <= 7'd0;
            parity_q  <= 1'b0;
            line_q    <= 1'b1;
        end else begin
            state     <= state_nx;
            cyc_cnt   <= cyc_nx;
            bit_cnt   <= bit_nx;
            shift_reg <= shift_nx;
            parity_q  <= parity_nx;
            line_q    <= line_nx;
        end
    end

endmodule
